// File: rtl/cos_bus_pkg.sv
`default_nettype none
// ============================================================================
// cos_bus_pkg : shared phase numbering and request record for the COSMAC-style
//               bus master.
// Revision    : 1.0
// ============================================================================
package cos_bus_pkg;

  typedef logic [2:0] ph_t;

  localparam ph_t PH_TPA      = 3'd1;
  localparam ph_t PH_LOADDR   = 3'd3;
  localparam ph_t PH_DOE      = 3'd4;
  localparam ph_t PH_WR_FIRST = 3'd5;
  localparam ph_t PH_WR_LAST  = 3'd6;
  localparam ph_t PH_WAIT     = 3'd6;
  localparam ph_t PH_TPB      = 3'd7;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cos_req_t;

endpackage
`default_nettype wire

// File: rtl/cos_bus_master_if.sv
`default_nettype none
// ============================================================================
// cos_bus_master_if : host request port, response port and external memory
//                     bus of the COSMAC-style bus master.
// Revision          : 1.0
// ============================================================================
interface cos_bus_master_if;
  logic       clr_n;
  logic       nwait;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [15:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_we;
  logic [7:0] rsp_rdata;
  logic       xclk;
  logic       tpa;
  logic       tpb;
  logic [7:0] ma;
  logic       nmrd;
  logic       nmwr;
  logic       db_oe;
  logic [7:0] db_do;
  logic [7:0] db_di;

  modport master (
    input  clr_n, nwait, req_valid, req_we, req_addr, req_wdata, db_di,
    output req_ready, rsp_valid, rsp_we, rsp_rdata,
    output xclk, tpa, tpb, ma, nmrd, nmwr, db_oe, db_do
  );

  modport slave (
    output clr_n, nwait, req_valid, req_we, req_addr, req_wdata, db_di,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata,
    input  xclk, tpa, tpb, ma, nmrd, nmwr, db_oe, db_do
  );
endinterface
`default_nettype wire

// File: rtl/cos_phase_timer.sv
`default_nettype none
// ============================================================================
// cos_phase_timer : bus-phase divider and 8-phase counter with wait hold at the
//                   end of phase 6 and clear from clr_n.
// Revision        : 1.0
// ============================================================================
module cos_phase_timer
  import cos_bus_pkg::*;
#(
  parameter int XCLK_DIV = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr_n,
  input  logic i_nwait,
  output ph_t  o_ph,
  output logic o_last,
  output ph_t  o_ph_nxt,
  output logic o_last_nxt,
  output logic o_xclk
);

  localparam int            DW         = $clog2(XCLK_DIV);
  localparam logic [DW-1:0] c_div_max  = DW'(XCLK_DIV - 1);
  localparam logic [DW-1:0] c_div_half = DW'(XCLK_DIV / 2);

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  ph_t           r_ph;
  ph_t           w_ph_nxt;
  logic          r_xclk;
  logic          w_last;
  logic          w_hold;

  assign w_last = (r_div == c_div_max);
  assign w_hold = w_last && (r_ph == PH_WAIT) && !i_nwait;

  always_comb begin
    w_div_nxt = r_div;
    w_ph_nxt  = r_ph;
    if (!i_clr_n) begin
      w_div_nxt = '0;
      w_ph_nxt  = '0;
    end else if (!w_hold) begin
      if (w_last) begin
        w_div_nxt = '0;
        w_ph_nxt  = r_ph + 3'd1;
      end else begin
        w_div_nxt = r_div + DW'(1);
      end
    end
  end

  // xclk is registered from the next divider value so it lines up with the
  // registered strobes in the top level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div  <= '0;
      r_ph   <= '0;
      r_xclk <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_ph   <= w_ph_nxt;
      r_xclk <= (w_div_nxt >= c_div_half);
    end
  end

  assign o_ph       = r_ph;
  assign o_last     = w_last;
  assign o_ph_nxt   = w_ph_nxt;
  assign o_last_nxt = (w_div_nxt == c_div_max);
  assign o_xclk     = r_xclk;

endmodule
`default_nettype wire

// File: rtl/cos_bus_master.sv
`default_nettype none
// ============================================================================
// cos_bus_master : COSMAC-style bus initiator; turns host requests into timed
//                  machine cycles (TPA/TPB, muxed MA, /MRD, /MWR, data bus).
// Revision       : 1.0
// ============================================================================
module cos_bus_master
  import cos_bus_pkg::*;
#(
  parameter int XCLK_DIV = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  cos_bus_master_if.master     bus
);

  ph_t  w_ph;
  ph_t  w_ph_nxt;
  logic w_last;
  logic w_last_nxt;
  logic w_xclk;

  cos_phase_timer #(
    .XCLK_DIV (XCLK_DIV)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .i_clr_n    (bus.clr_n),
    .i_nwait    (bus.nwait),
    .o_ph       (w_ph),
    .o_last     (w_last),
    .o_ph_nxt   (w_ph_nxt),
    .o_last_nxt (w_last_nxt),
    .o_xclk     (w_xclk)
  );

  cos_req_t   r_req;
  cos_req_t   w_req_nxt;
  cos_req_t   w_req_in;
  logic       r_act;
  logic       w_act_nxt;
  logic       w_end;
  logic       w_acc;
  logic       r_ready;

  logic       r_tpa, r_tpb, r_nmrd, r_nmwr, r_oe;
  logic [7:0] r_ma, r_do;
  logic       w_tpa, w_tpb, w_nmrd, w_nmwr, w_oe;
  logic [7:0] w_ma, w_do;

  logic       r_rsp_valid;
  logic       r_rsp_we;
  logic [7:0] r_rsp_rdata;

  assign w_req_in = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};

  assign bus.req_ready = r_ready && bus.clr_n && resetn;
  assign w_acc         = bus.req_valid && bus.req_ready;
  assign w_end         = (w_ph == PH_TPB) && w_last && bus.clr_n;

  // The cycle that starts on this edge takes the request accepted right now,
  // so strobes for phase 0 already reflect it.
  always_comb begin
    w_act_nxt = r_act;
    w_req_nxt = r_req;
    if (!bus.clr_n) begin
      w_act_nxt = 1'b0;
    end else if (w_end) begin
      w_act_nxt = w_acc;
      if (w_acc) begin
        w_req_nxt = w_req_in;
      end
    end
  end

  always_comb begin
    w_tpa  = (w_ph_nxt == PH_TPA);
    w_tpb  = (w_ph_nxt == PH_TPB);
    w_nmrd = 1'b1;
    w_nmwr = 1'b1;
    w_ma   = '0;
    w_oe   = 1'b0;
    w_do   = '0;
    if (w_act_nxt) begin
      w_ma = (w_ph_nxt < PH_LOADDR) ? w_req_nxt.addr[15:8] : w_req_nxt.addr[7:0];
      if (w_req_nxt.we) begin
        if (w_ph_nxt >= PH_DOE) begin
          w_oe = 1'b1;
          w_do = w_req_nxt.wdata;
        end
        if ((w_ph_nxt >= PH_WR_FIRST) && (w_ph_nxt <= PH_WR_LAST)) begin
          w_nmwr = 1'b0;
        end
      end else begin
        w_nmrd = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_act   <= 1'b0;
      r_req   <= '0;
      r_ready <= 1'b0;
      r_tpa   <= 1'b0;
      r_tpb   <= 1'b0;
      r_nmrd  <= 1'b1;
      r_nmwr  <= 1'b1;
      r_ma    <= '0;
      r_oe    <= 1'b0;
      r_do    <= '0;
    end else begin
      r_act   <= w_act_nxt;
      r_req   <= w_req_nxt;
      r_ready <= bus.clr_n && (w_ph_nxt == PH_TPB) && w_last_nxt;
      r_tpa   <= w_tpa;
      r_tpb   <= w_tpb;
      r_nmrd  <= w_nmrd;
      r_nmwr  <= w_nmwr;
      r_ma    <= w_ma;
      r_oe    <= w_oe;
      r_do    <= w_do;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_end && r_act) begin
        r_rsp_valid <= 1'b1;
        r_rsp_we    <= r_req.we;
        r_rsp_rdata <= r_req.we ? 8'h00 : bus.db_di;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_we    = r_rsp_we;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.xclk      = w_xclk;
  assign bus.tpa       = r_tpa;
  assign bus.tpb       = r_tpb;
  assign bus.ma        = r_ma;
  assign bus.nmrd      = r_nmrd;
  assign bus.nmwr      = r_nmwr;
  assign bus.db_oe     = r_oe;
  assign bus.db_do     = r_do;

endmodule
`default_nettype wire
